uart_rx_deser_p: RTL and testbench
==================================

# uart_rx_deser_p

Parametrised UART receive deserializer. It oversamples the serial line at `prescale` clocks per bit and assembles `DATA_WIDTH` data bits into a parallel word. It presents the word with a one-cycle valid strobe. It sits between the RX framing FSM, which owns start/parity/stop handling and drives `deser_en`, and the parity/stop checkers that consume `p_data`.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; legal range 5..9.
- `PRESCALE_W`, default 6: width of the `prescale` port.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `deser_en`  in  1  frame enable from the framing FSM; high for the whole data field.
- `prescale`  in  PRESCALE_W  clocks per bit; legal 4..2^PRESCALE_W-1.
- `msb_first`  in  1  bit order; 0 = LSB first (UART default), 1 = MSB first.
- `rx_in`  in  1  serial line, already synchronised upstream.
- `p_data`  out  DATA_WIDTH  last completed word.
- `data_valid`  out  1  one-cycle strobe when `p_data` updates.
- `busy`  out  1  high while a frame is being assembled.

## Operation
- Reset values:
  - state IDLE;
  - `p_data`=0, `data_valid`=0, `busy`=0;
  - internal counters and shift register 0.
- State IDLE:
  - Any cycle with `deser_en`=1 starts a frame and moves to SHIFT.
  - On start, latch `prescale` into P and `msb_first` into the order bit.
  - Clear `edge_cnt`, `bit_cnt` and the shift register.
  - P < 4 is latched as 4.
  - Changes to `prescale` or `msb_first` mid-frame are ignored.
- State SHIFT:
  - `edge_cnt` counts 0..P-1 and wraps to 0.
  - `bit_cnt` increments on each wrap.
  - Sample point H = P>>1.
  - The bit decision is taken at `edge_cnt`==H; see Configuration for the sampling scheme.
  - LSB first: shift right; the new bit enters [DATA_WIDTH-1].
  - MSB first: shift left; the new bit enters [0].
- Frame completion:
  - Occurs on the cycle `edge_cnt`==P-1 with `bit_cnt`==DATA_WIDTH-1.
  - Load `p_data` from the final shift-register contents, including the bit decided this frame.
  - Assert `data_valid` for one cycle; return to IDLE.
- Abort: `deser_en`=0 in SHIFT returns to IDLE on the next edge.
  - No `data_valid` is issued.
  - `p_data` holds its previous value.
  - The shift register is cleared.
- Back-to-back frames: if `deser_en` is still 1 in the cycle after completion, a new frame starts immediately from IDLE.
- `p_data` changes only on completion or reset.
- `busy` = (state==SHIFT), registered.

## Timing
- Let T0 be the edge at which IDLE samples `deser_en`=1.
  - `busy` rises at T0+1.
  - In cycle T0+1+j, `edge_cnt` = j mod P.
- Bit k is decided at cycle T0+1+k·P+H.
- `p_data` and `data_valid` are visible at T0+1+DATA_WIDTH·P.
  - For P=8 and DATA_WIDTH=8 this is T0+65.
  - `busy` falls in the same cycle.
- Latency from the last bit's sample point to valid: P-H cycles.
- Reset asserted mid-frame clears everything asynchronously.
  - No `data_valid` is issued.
  - The first frame after release needs `deser_en` sampled high in IDLE.

## Configuration
- Macro: `UART_RX_DESER_MAJORITY_EN`.
- Defined:
  - sample `rx_in` at `edge_cnt` = H-1, H and H+1;
  - the bit is the 2-of-3 majority;
  - the decision, and the shift, occur at H+1 instead of H;
  - valid timing is unchanged.
  - Requires P ≥ 4, which the clamp guarantees.
- Undefined: single sample of `rx_in` at `edge_cnt`==H; no vote registers.

## Test plan
- LSB-first word: DATA_WIDTH=8, P=8, `msb_first`=0; drive line bits 1,0,1,0,0,1,0,1 with T0=0.
  - Required: `p_data`=0xA5 and `data_valid`=1 only at cycle 65; `busy` 1 for cycles 1..64.
- MSB-first word: same bit stream, `msb_first`=1.
  - Required: `p_data`=0xA5; `prescale` changed to 12 mid-frame still gives valid at cycle 65.
- Abort mid-frame: `p_data` preloaded with 0x3C; drop `deser_en` after 3 bits.
  - Required: no `data_valid`; `p_data` stays 0x3C; `busy`=0 one cycle later.
- Glitch rejection: invert `rx_in` for one cycle at `edge_cnt`==H on bit 2 of 0x00.
  - With `UART_RX_DESER_MAJORITY_EN`: `p_data`=0x00.
  - Without it: `p_data`=0x04.
- Parameter, back-to-back and reset: DATA_WIDTH=5, P=16; two frames 0x15 then 0x0A with `deser_en` held high.
  - Required: valids at T0+81 and T0+162 with correct words.
  - Assert `rst` mid-third frame: all outputs 0 immediately.

Source files
------------

// File: rtl/uart_rx_deser_p.sv
// UART receive deserializer: oversamples rx_in at prescale clocks per bit and assembles DATA_WIDTH bits.
// Define UART_RX_DESER_MAJORITY_EN for 2-of-3 majority sampling around the bit centre.
module uart_rx_deser_p #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  deser_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  msb_first,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  busy
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0]         LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] MIN_P    = PRESCALE_W'(4);
    localparam logic [PRESCALE_W-1:0] ONE_P    = PRESCALE_W'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state;
    logic [PRESCALE_W-1:0]   p_lat;
    logic [PRESCALE_W-1:0]   edge_cnt;
    logic [PRESCALE_W-1:0]   half;
    logic [BW-1:0]           bit_cnt;
    logic                    order;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [DATA_WIDTH-1:0]   shreg_next;
    logic                    sample_now;
    logic                    bit_val;
    logic                    last_edge;
    logic                    frame_done;

    assign half       = p_lat >> 1;
    assign last_edge  = (edge_cnt == p_lat - ONE_P);
    assign frame_done = last_edge && (bit_cnt == LAST_BIT);

`ifdef UART_RX_DESER_MAJORITY_EN
    logic vote_a;
    logic vote_b;

    // The third vote is the live line at H+1, so the decision lands one cycle after the centre.
    assign sample_now = (edge_cnt == half + ONE_P);
    assign bit_val    = (vote_a & vote_b) | (vote_a & rx_in) | (vote_b & rx_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_a <= 1'b0;
            vote_b <= 1'b0;
        end else if (state == SHIFT) begin
            if (edge_cnt == half - ONE_P)
                vote_a <= rx_in;
            if (edge_cnt == half)
                vote_b <= rx_in;
        end
    end
`else
    assign sample_now = (edge_cnt == half);
    assign bit_val    = rx_in;
`endif

    // With P=4 under majority voting the last decision coincides with completion, so p_data loads from here.
    always_comb begin
        shreg_next = shreg;
        if (sample_now) begin
            if (order)
                shreg_next = {shreg[DATA_WIDTH-2:0], bit_val};
            else
                shreg_next = {bit_val, shreg[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            p_lat      <= '0;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            order      <= 1'b0;
            shreg      <= '0;
            p_data     <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (deser_en) begin
                        state    <= SHIFT;
                        busy     <= 1'b1;
                        p_lat    <= (prescale < MIN_P) ? MIN_P : prescale;
                        order    <= msb_first;
                        edge_cnt <= '0;
                        bit_cnt  <= '0;
                        shreg    <= '0;
                    end
                end
                SHIFT: begin
                    if (!deser_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        shreg <= '0;
                    end else begin
                        shreg <= shreg_next;
                        if (last_edge) begin
                            edge_cnt <= '0;
                            bit_cnt  <= bit_cnt + BW'(1);
                        end else begin
                            edge_cnt <= edge_cnt + ONE_P;
                        end
                        if (frame_done) begin
                            p_data     <= shreg_next;
                            data_valid <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deser_p.sv
// Bench for uart_rx_deser_p: 8-bit and 5-bit instances share one stimulus stream and are
// compared every cycle against a frame-level reference model, plus directed scenario checks.
module tb_uart_rx_deser_p;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       deser_en;
    logic [5:0] prescale;
    logic       msb_first;
    logic       rx_in;
    logic [7:0] p_data8;
    logic [4:0] p_data5;
    logic       dv8, dv5, busy8, busy5;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    int v8_last  = -1;
    int v5_last  = -1;
    int v8_cnt   = 0;

    always #5 clk = ~clk;

    uart_rx_deser_p #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut8 (
        .clk(clk), .rst(rst), .deser_en(deser_en), .prescale(prescale),
        .msb_first(msb_first), .rx_in(rx_in), .p_data(p_data8),
        .data_valid(dv8), .busy(busy8)
    );

    uart_rx_deser_p #(.DATA_WIDTH(5), .PRESCALE_W(6)) dut5 (
        .clk(clk), .rst(rst), .deser_en(deser_en), .prescale(prescale),
        .msb_first(msb_first), .rx_in(rx_in), .p_data(p_data5),
        .data_valid(dv5), .busy(busy5)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: each frame is a position j = cycles since start; bit k = j / P, phase = j % P.
    logic       m_active [2];
    int         m_j      [2];
    int         m_p      [2];
    logic       m_ord    [2];
    logic [8:0] m_bits   [2];
    logic [8:0] exp_data [2];
    logic       exp_valid[2];
    logic       exp_busy [2];
`ifdef UART_RX_DESER_MAJORITY_EN
    logic       m_s0     [2];
    logic       m_s1     [2];
`endif

    task automatic modelEdge(input int i);
        int w, h, ph, k;
        logic [8:0] d;
        w = (i == 0) ? 8 : 5;
        exp_valid[i] = 1'b0;
        if (!m_active[i]) begin
            if (deser_en) begin
                m_active[i] = 1'b1;
                m_p[i]      = (int'(prescale) < 4) ? 4 : int'(prescale);
                m_ord[i]    = msb_first;
                m_j[i]      = 0;
                m_bits[i]   = '0;
            end
        end else if (!deser_en) begin
            m_active[i] = 1'b0;
        end else begin
            h  = m_p[i] / 2;
            ph = m_j[i] % m_p[i];
            k  = m_j[i] / m_p[i];
`ifdef UART_RX_DESER_MAJORITY_EN
            if (ph == h - 1) m_s0[i] = rx_in;
            if (ph == h)     m_s1[i] = rx_in;
            if (ph == h + 1) m_bits[i][k] = (m_s0[i] & m_s1[i]) | (m_s0[i] & rx_in) | (m_s1[i] & rx_in);
`else
            if (ph == h) m_bits[i][k] = rx_in;
`endif
            if (m_j[i] == w * m_p[i] - 1) begin
                d = '0;
                for (int b = 0; b < w; b++)
                    d[m_ord[i] ? (w - 1 - b) : b] = m_bits[i][b];
                exp_data[i]  = d;
                exp_valid[i] = 1'b1;
                m_active[i]  = 1'b0;
            end else begin
                m_j[i]++;
            end
        end
        exp_busy[i] = m_active[i];
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_active[i]  = 1'b0;
                m_j[i]       = 0;
                m_p[i]       = 4;
                m_ord[i]     = 1'b0;
                m_bits[i]    = '0;
                exp_data[i]  = '0;
                exp_valid[i] = 1'b0;
                exp_busy[i]  = 1'b0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++)
                modelEdge(i);
        end
    end

    always @(negedge clk) begin
        checkOutput("p_data8", 32'(p_data8), 32'(exp_data[0]));
        checkOutput("valid8",  32'(dv8),     32'(exp_valid[0]));
        checkOutput("busy8",   32'(busy8),   32'(exp_busy[0]));
        checkOutput("p_data5", 32'(p_data5), 32'(exp_data[1]));
        checkOutput("valid5",  32'(dv5),     32'(exp_valid[1]));
        checkOutput("busy5",   32'(busy5),   32'(exp_busy[1]));
        if (dv8 === 1'b1) begin
            v8_last = cyc;
            v8_cnt++;
        end
        if (dv5 === 1'b1)
            v5_last = cyc;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame starting at the next edge; on return the word's valid cycle is current.
    task automatic applyStimulus(input logic [8:0] word, input int nbits, input int p,
                                 input bit msb, input int glitch_bit, input int mid_pre);
        int pc, h;
        logic b;
        pc = (p < 4) ? 4 : p;
        h  = pc / 2;
        prescale  = 6'(p);
        msb_first = msb;
        deser_en  = 1'b1;
        step();
        t0 = cyc - 1;
        for (int k = 0; k < nbits; k++) begin
            b = msb ? word[nbits - 1 - k] : word[k];
            for (int c = 0; c < pc; c++) begin
                rx_in = (k == glitch_bit && c == h) ? ~b : b;
                if (k == 1 && c == 0 && mid_pre != 0) begin
                    prescale  = 6'(mid_pre);
                    msb_first = ~msb;
                end
                step();
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ta, cnt_before, nb, p, mid, gl;
        logic [8:0] w;
        deser_en  = 1'b0;
        prescale  = 6'd8;
        msb_first = 1'b0;
        rx_in     = 1'b1;
        #1 rst = 1'b1;
        repeat (2) step();
        checkOutput("rst_pdata8", 32'(p_data8), 32'h0);
        checkOutput("rst_valid8", 32'(dv8),     32'h0);
        checkOutput("rst_busy8",  32'(busy8),   32'h0);
        rst = 1'b0;
        repeat (3) step();

        applyStimulus(9'h0A5, 8, 8, 1'b0, -1, 0);
        #5;
        checkOutput("lsb_word",    32'(p_data8), 32'hA5);
        checkOutput("lsb_valid",   32'(dv8),     32'h1);
        checkOutput("lsb_vcycle",  32'(v8_last - t0), 32'd65);
        deser_en = 1'b0;
        repeat (3) step();

        applyStimulus(9'h0A5, 8, 8, 1'b1, -1, 12);
        #5;
        checkOutput("msb_word",   32'(p_data8), 32'hA5);
        checkOutput("msb_vcycle", 32'(v8_last - t0), 32'd65);
        deser_en = 1'b0;
        repeat (3) step();

        applyStimulus(9'h03C, 8, 4, 1'b0, -1, 0);
        #5;
        checkOutput("preload_word", 32'(p_data8), 32'h3C);
        deser_en = 1'b0;
        repeat (2) step();
        cnt_before = v8_cnt;
        applyStimulus(9'h0FF, 3, 8, 1'b0, -1, 0);
        deser_en = 1'b0;
        step();
        #5;
        checkOutput("abort_busy",   32'(busy8),   32'h0);
        checkOutput("abort_pdata",  32'(p_data8), 32'h3C);
        checkOutput("abort_nvalid", 32'(v8_cnt),  32'(cnt_before));
        repeat (2) step();

        applyStimulus(9'h000, 8, 8, 1'b0, 2, 0);
        #5;
`ifdef UART_RX_DESER_MAJORITY_EN
        checkOutput("glitch_word", 32'(p_data8), 32'h00);
`else
        checkOutput("glitch_word", 32'(p_data8), 32'h04);
`endif
        deser_en = 1'b0;
        repeat (3) step();

        applyStimulus(9'h015, 5, 16, 1'b0, -1, 0);
        ta = t0;
        #5;
        checkOutput("b2b_word1",   32'(p_data5), 32'h15);
        checkOutput("b2b_vcycle1", 32'(v5_last - ta), 32'd81);
        applyStimulus(9'h00A, 5, 16, 1'b0, -1, 0);
        #5;
        checkOutput("b2b_word2",   32'(p_data5), 32'h0A);
        checkOutput("b2b_vcycle2", 32'(v5_last - ta), 32'd162);
        step();
        repeat (40) step();
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_pdata5", 32'(p_data5), 32'h0);
        checkOutput("midrst_busy5",  32'(busy5),   32'h0);
        checkOutput("midrst_pdata8", 32'(p_data8), 32'h0);
        checkOutput("midrst_busy8",  32'(busy8),   32'h0);
        checkOutput("midrst_valid",  32'({dv8, dv5}), 32'h0);
        #3 rst = 1'b0;
        repeat (90) step();
        deser_en = 1'b0;
        repeat (3) step();

        for (int n = 0; n < 40; n++) begin
            deser_en = 1'b0;
            repeat ($urandom_range(0, 3)) step();
            p   = $urandom_range(0, 20);
            w   = 9'($urandom);
            gl  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1;
            mid = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 20) : 0;
            nb  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
            applyStimulus(w, nb, p, 1'($urandom), gl, mid);
            if ($urandom_range(0, 1) == 0) begin
                deser_en = 1'b0;
                step();
            end
        end
        deser_en = 1'b0;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
